// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared seven-segment types, the blank pattern and the
//               active-low hex glyph table (bit0 = a ... bit6 = g).
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;
    typedef logic [3:0]       nibble_t;

    // All segments high: every segment of a common-anode digit is dark.
    localparam seg_t SEG_OFF = 7'h7F;

    // Active-low glyphs for 0-9, A, b, C, d, E, F.
    localparam seg_t HEX_LUT [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg
// Description : Combinational hex nibble to active-low seven-segment glyph.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  nibble_t i_nibble,
    output seg_t    o_seg
);

    // Direct table lookup; every nibble value has a glyph.
    assign o_seg = HEX_LUT[i_nibble];

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_driver
// Description : Time-multiplexed common-anode seven-segment driver with
//               per-digit dp/blank/blink and frame-boundary data commit.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    output logic [SEG_W-1:0]        segment,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_start
);

    localparam int c_PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W = $clog2(NUM_DIGITS);
    localparam int c_FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_FRM_W-1:0] c_FRM_LAST = c_FRM_W'(BLINK_FRAMES - 1);

    // One complete set of display attributes (pending or active).
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
        logic [NUM_DIGITS-1:0]   blink;
    } disp_set_t;

    logic [c_PRE_W-1:0]    r_prescaler;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_FRM_W-1:0]    r_frm_cnt;
    logic                  r_phase;
    logic                  r_pend_valid;
    disp_set_t             r_pend;
    disp_set_t             r_act;
    seg_t                  r_segment;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_anode;
    logic                  r_frame_start;

    disp_set_t             w_in;
    logic                  w_slot_adv;
    logic                  w_commit;
    nibble_t               w_digit;
    seg_t                  w_glyph;
    logic                  w_dark;
    logic [NUM_DIGITS-1:0] w_anode;

    // Gather the input buses into one set, and decode slot/frame events.
    always_comb begin
        w_in.digits = digits_in;
        w_in.dp     = dp_in;
        w_in.blank  = blank_in;
        w_in.blink  = blink_in;
        w_slot_adv  = enable && (r_prescaler == c_PRE_LAST);
        w_commit    = w_slot_adv && (r_idx == c_IDX_LAST);
        w_digit     = r_act.digits[{r_idx, 2'b00} +: 4];
        w_dark      = r_act.blank[r_idx] | (r_act.blink[r_idx] & r_phase);
        w_anode     = ~(NUM_DIGITS'(1) << r_idx);
    end

    hex_to_seg u_hex_to_seg (
        .i_nibble (w_digit),
        .o_seg    (w_glyph)
    );

    // Prescaler and slot index; both freeze while scanning is disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prescaler <= '0;
            r_idx       <= '0;
        end else if (enable) begin
            if (w_slot_adv) begin
                r_prescaler <= '0;
                r_idx       <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_prescaler <= r_prescaler + 1'b1;
            end
        end
    end

    // Frame counter toggles the blink phase every BLINK_FRAMES commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frm_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (w_commit) begin
            if (r_frm_cnt == c_FRM_LAST) begin
                r_frm_cnt <= '0;
                r_phase   <= ~r_phase;
            end else begin
                r_frm_cnt <= r_frm_cnt + 1'b1;
            end
        end
    end

    // Double buffer: loads land in pending, the active set changes only at
    // the frame wrap, and a load on the wrap cycle bypasses pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend       <= '0;
            r_act.digits <= '0;
            r_act.dp     <= '0;
            r_act.blank  <= '1;
            r_act.blink  <= '0;
        end else if (w_commit) begin
            r_pend_valid <= 1'b0;
            if (load) begin
                r_act <= w_in;
            end else if (r_pend_valid) begin
                r_act <= r_pend;
            end
        end else if (load) begin
            r_pend       <= w_in;
            r_pend_valid <= 1'b1;
        end
    end

    // Registered pin drive for the current slot; dark while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_segment     <= SEG_OFF;
            r_dp          <= 1'b1;
            r_anode       <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_commit;
            if (!enable) begin
                r_segment <= SEG_OFF;
                r_dp      <= 1'b1;
                r_anode   <= '1;
            end else begin
                r_anode <= w_anode;
                if (w_dark) begin
                    r_segment <= SEG_OFF;
                    r_dp      <= 1'b1;
                end else begin
                    r_segment <= w_glyph;
                    r_dp      <= ~r_act.dp[r_idx];
                end
            end
        end
    end

    assign segment     = r_segment;
    assign dp          = r_dp;
    assign anode       = r_anode;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_driver
// Description : Directed scenarios plus randomized traffic checked against a
//               cycle-count based behavioural model of the scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BF = 1;
    localparam int FR = ND * RD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  blink_in = '0;
    logic [6:0]  segment;
    logic        dp;
    logic [3:0]  anode;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .blink_in    (blink_in),
        .segment     (segment),
        .dp          (dp),
        .anode       (anode),
        .frame_start (frame_start)
    );

    logic [6:0] glyph_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] glyph(input logic [3:0] h);
        return glyph_tab[h];
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input int s);
        return 4'((v >> (4 * s)) & 16'hF);
    endfunction

    function automatic int slot_of_anode(input logic [3:0] a);
        for (int i = 0; i < ND; i++) begin
            if (a == ~(4'b0001 << i)) return i;
        end
        return -1;
    endfunction

    // ---------------- behavioural model ----------------
    // Time is counted in enabled cycles since reset; slot and frame wrap are
    // derived arithmetically from that count.
    int          m_n;
    int          m_commits;
    logic [15:0] m_dig, p_dig;
    logic [3:0]  m_dp, m_bl, m_bk, p_dp, p_bl, p_bk;
    logic        m_pv;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs;
    logic [3:0]  e_anode;

    function automatic logic m_dark(input int s);
        return m_bl[s] | (m_bk[s] & (((m_commits / BF) % 2) == 1));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_n <= 0; m_commits <= 0; m_pv <= 1'b0;
            m_dig <= '0; m_dp <= '0; m_bl <= '1; m_bk <= '0;
            p_dig <= '0; p_dp <= '0; p_bl <= '0; p_bk <= '0;
            e_seg <= 7'h7F; e_dp <= 1'b1; e_anode <= 4'hF; e_fs <= 1'b0;
        end else begin
            if (enable) begin
                e_anode <= ~(4'b0001 << ((m_n / RD) % ND));
                e_seg   <= m_dark((m_n / RD) % ND) ? 7'h7F : glyph(nib(m_dig, (m_n / RD) % ND));
                e_dp    <= m_dark((m_n / RD) % ND) ? 1'b1 : ~m_dp[(m_n / RD) % ND];
                m_n     <= m_n + 1;
            end else begin
                e_anode <= 4'hF; e_seg <= 7'h7F; e_dp <= 1'b1;
            end
            e_fs <= enable && ((m_n % FR) == FR - 1);
            if (enable && ((m_n % FR) == FR - 1)) begin
                m_commits <= m_commits + 1;
                m_pv      <= 1'b0;
                if (load) begin
                    m_dig <= digits_in; m_dp <= dp_in; m_bl <= blank_in; m_bk <= blink_in;
                end else if (m_pv) begin
                    m_dig <= p_dig; m_dp <= p_dp; m_bl <= p_bl; m_bk <= p_bk;
                end
            end else if (load) begin
                p_dig <= digits_in; p_dp <= dp_in; p_bl <= blank_in; p_bk <= blink_in;
                m_pv  <= 1'b1;
            end
        end
    end

    // Waits (bounded) for the next frame_start pulse.
    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (anode !== 4'hF || segment !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: anode=%h seg=%h dp=%b fs=%b, expected F/7F/1/0",
                     anode, segment, dp, frame_start);
        end
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            n_checks++;
            if (segment !== 7'h7F || dp !== 1'b1 || frame_start !== (k == 16)) begin
                n_fail++;
                $display("FAIL dark_first_frame cyc%0d: seg=%h dp=%b fs=%b, expected 7F/1/%b",
                         k, segment, dp, frame_start, (k == 16));
            end
        end
    endtask

    task automatic test_load_display();
        logic [6:0] exp_seg [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
        bit ok;
        digits_in = 16'h12AF; dp_in = 4'b0100; blank_in = '0; blink_in = '0;
        load = 1'b1; @(negedge clk); load = 1'b0;
        wait_frame(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL load_frame_timeout: no frame_start seen, expected one"); end
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            n_checks++;
            if (anode !== ~(4'b0001 << ((k / 4) % 4)) || segment !== exp_seg[(k / 4) % 4] ||
                dp !== (((k / 4) % 4) != 2)) begin
                n_fail++;
                $display("FAIL scan_12AF cyc%0d: anode=%h seg=%h dp=%b, expected %h/%h/%b", k,
                         anode, segment, dp, ~(4'b0001 << ((k / 4) % 4)), exp_seg[(k / 4) % 4],
                         (((k / 4) % 4) != 2));
            end
        end
    endtask

    task automatic test_load_mid_frame();
        bit ok;
        bit seen;
        int s;
        digits_in = 16'h1234; dp_in = '0; blank_in = '0; blink_in = '0;
        load = 1'b1; @(negedge clk); load = 1'b0;
        wait_frame(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL mid_frame_timeout: no frame_start seen, expected one"); end
        repeat (6) @(negedge clk);
        digits_in = 16'h5678;
        load = 1'b1; @(negedge clk); load = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            s = slot_of_anode(anode);
            n_checks++;
            if (s < 0 || segment !== glyph(nib(16'h1234, s))) begin
                n_fail++;
                $display("FAIL old_frame_kept: anode=%h seg=%h, expected glyph of 1234 for that slot",
                         anode, segment);
            end
            if (frame_start === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL mid_frame_wrap: frame_start=0, expected 1"); end
        @(negedge clk);
        n_checks++;
        if (anode !== 4'hE || segment !== 7'h00) begin
            n_fail++;
            $display("FAIL new_digit0: anode=%h seg=%h, expected E/00", anode, segment);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (anode !== 4'hD || segment !== 7'h78) begin
            n_fail++;
            $display("FAIL new_digit1: anode=%h seg=%h, expected D/78", anode, segment);
        end
    endtask

    task automatic test_load_on_wrap();
        bit ok;
        logic [15:0] va = 16'h9C3E;
        logic [15:0] vb = 16'h0D75;
        wait_frame(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wrap_timeout: no frame_start seen, expected one"); end
        repeat (15) @(negedge clk);
        digits_in = va;
        load = 1'b1; @(negedge clk); load = 1'b0;
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++; $display("FAIL wrap_alignment: frame_start=%b, expected 1", frame_start);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if (anode !== ~(4'b0001 << (i / 4)) || segment !== glyph(nib(va, i / 4))) begin
                n_fail++;
                $display("FAIL wrap_load_immediate cyc%0d: anode=%h seg=%h, expected %h/%h", i,
                         anode, segment, ~(4'b0001 << (i / 4)), glyph(nib(va, i / 4)));
            end
            if (i == 5) begin digits_in = vb; load = 1'b1; end
            else load = 1'b0;
        end
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++; $display("FAIL wrap_second_frame: frame_start=%b, expected 1", frame_start);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if (anode !== ~(4'b0001 << (i / 4)) || segment !== glyph(nib(vb, i / 4))) begin
                n_fail++;
                $display("FAIL second_load_deferred cyc%0d: anode=%h seg=%h, expected %h/%h", i,
                         anode, segment, ~(4'b0001 << (i / 4)), glyph(nib(vb, i / 4)));
            end
        end
    endtask

    task automatic test_blink();
        bit ok;
        logic [6:0] s0 [4];
        digits_in = 16'h4321; dp_in = '0; blank_in = '0; blink_in = 4'b0001;
        load = 1'b1; @(negedge clk); load = 1'b0;
        blink_in = '0;
        wait_frame(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL blink_timeout: no frame_start seen, expected one"); end
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (i == 0) s0[f] = segment;
                n_checks++;
                if (i / 4 != 0 && segment !== glyph(nib(16'h4321, i / 4))) begin
                    n_fail++;
                    $display("FAIL blink_other_digit f%0d cyc%0d: seg=%h, expected %h", f, i,
                             segment, glyph(nib(16'h4321, i / 4)));
                end else if (i / 4 == 0 && segment !== s0[f]) begin
                    n_fail++;
                    $display("FAIL blink_slot_stable f%0d cyc%0d: seg=%h, expected %h", f, i,
                             segment, s0[f]);
                end
            end
            n_checks++;
            if ((s0[f] !== 7'h79 && s0[f] !== 7'h7F) || (f > 0 && s0[f] === s0[f-1])) begin
                n_fail++;
                $display("FAIL blink_toggle f%0d: seg=%h, expected the other of 79/7F", f, s0[f]);
            end
        end
    endtask

    task automatic test_enable_reset();
        bit ok;
        logic [3:0] exp_an [10] = '{4'hD, 4'hD, 4'hB, 4'hB, 4'hB, 4'hB, 4'h7, 4'h7, 4'h7, 4'h7};
        wait_frame(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL pause_timeout: no frame_start seen, expected one"); end
        repeat (6) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (anode !== 4'hF || segment !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
                n_fail++;
                $display("FAIL paused_dark cyc%0d: anode=%h seg=%h dp=%b fs=%b, expected F/7F/1/0",
                         i, anode, segment, dp, frame_start);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (anode !== exp_an[i] || frame_start !== (i == 9)) begin
                n_fail++;
                $display("FAIL resume_no_skip cyc%0d: anode=%h fs=%b, expected %h/%b", i, anode,
                         frame_start, exp_an[i], (i == 9));
            end
        end
        digits_in = 16'h0000; blank_in = '0; blink_in = '0;
        load = 1'b1; @(negedge clk); load = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (anode !== 4'hF || segment !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_state: anode=%h seg=%h dp=%b fs=%b, expected F/7F/1/0",
                     anode, segment, dp, frame_start);
        end
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            n_checks++;
            if (segment !== 7'h7F || dp !== 1'b1 || frame_start !== (k % 16 == 0)) begin
                n_fail++;
                $display("FAIL load_lost_after_reset cyc%0d: seg=%h dp=%b fs=%b, expected 7F/1/%b",
                         k, segment, dp, frame_start, (k % 16 == 0));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            n_checks++;
            if (segment !== e_seg || dp !== e_dp || anode !== e_anode || frame_start !== e_fs) begin
                n_fail++;
                $display("FAIL random cyc%0d: seg=%h dp=%b anode=%h fs=%b, expected %h/%b/%h/%b",
                         c, segment, dp, anode, frame_start, e_seg, e_dp, e_anode, e_fs);
            end
            reset     = ($urandom_range(0, 499) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            load      = ($urandom_range(0, 5) == 0);
            digits_in = 16'($urandom);
            dp_in     = 4'($urandom);
            blank_in  = 4'($urandom & $urandom & $urandom);
            blink_in  = 4'($urandom);
        end
        reset = 1'b0; load = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_load_display();
        test_load_mid_frame();
        test_load_on_wrap();
        test_blink();
        test_enable_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
